// File: rtl/ucpu_control_unit.sv
// Instruction fetch/decode sequencer for the micro-CPU.
// Fetches 16-bit instructions, steps DECODE/EXECUTE1/EXECUTE2 and drives the ALU interface controls.
module ucpu_control_unit #(
    parameter int ALU_WIDTH = 8,
    parameter int ALU_OPS   = 16,
    parameter int PC_WIDTH  = 8,
    parameter int A_REG_MAP = 16,
    parameter int B_REG_MAP = 17
) (
    input  logic                         sysclk,
    input  logic                         reset,
    output logic                         instr_req,
    output logic [PC_WIDTH-1:0]          instr_addr,
    input  logic                         instr_valid,
    input  logic [15:0]                  instr_data,
    input  logic                         cc_greater,
    input  logic                         cc_equal,
    output logic [1:0]                   control_state,
    output logic                         alu_en,
    output logic [$clog2(ALU_OPS)-1:0]   alu_op,
    output logic [4:0]                   reg_src,
    output logic [ALU_WIDTH-1:0]         operand_imm,
    output logic                         halted,
    output logic                         illegal_op
);

    localparam int OP_W = $clog2(ALU_OPS);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC1  = 3'd2;
    localparam logic [2:0] ST_EXEC2  = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDA  = 4'h1;
    localparam logic [3:0] OPC_LDB  = 4'h2;
    localparam logic [3:0] OPC_ALU  = 4'h3;
    localparam logic [3:0] OPC_BEQ  = 4'h4;
    localparam logic [3:0] OPC_BGT  = 4'h5;
    localparam logic [3:0] OPC_JMP  = 4'h6;
    localparam logic [3:0] OPC_HALT = 4'hF;

    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;

    logic [2:0]          w_nextState;
    logic [PC_WIDTH-1:0] w_nextPc;
    logic [3:0]          w_opcode;
    logic                w_illegal;
    logic                w_branchTaken;
    logic [PC_WIDTH-1:0] w_branchOffset;

    assign w_opcode       = r_ir[15:12];
    assign w_illegal      = (w_opcode >= 4'h7) && (w_opcode <= 4'hE);
    assign w_branchOffset = PC_WIDTH'($signed(r_ir[7:0]));
    assign w_branchTaken  = ((w_opcode == OPC_BEQ) && cc_equal) ||
                            ((w_opcode == OPC_BGT) && cc_greater);

    // Sequencing and program-counter update; branch flags matter only in EXECUTE1.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        case (r_state)
            ST_FETCH: begin
                if (instr_valid) begin
                    w_nextState = ST_DECODE;
                    w_nextPc    = r_pc + 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_opcode == OPC_HALT)
                    w_nextState = ST_HALT;
                else if ((w_opcode == OPC_NOP) || w_illegal)
                    w_nextState = ST_FETCH;
                else
                    w_nextState = ST_EXEC1;
            end
            ST_EXEC1: begin
                w_nextState = (w_opcode == OPC_ALU) ? ST_EXEC2 : ST_FETCH;
                if (w_opcode == OPC_JMP)
                    w_nextPc = r_ir[PC_WIDTH-1:0];
                else if (w_branchTaken)
                    w_nextPc = r_pc + w_branchOffset;
            end
            ST_EXEC2: w_nextState = ST_FETCH;
            ST_HALT:  w_nextState = ST_HALT;
            default:  w_nextState = ST_FETCH;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if ((r_state == ST_FETCH) && instr_valid)
                r_ir <= instr_data;
        end
    end

    // Outputs depend only on registered state, so there is no input-to-output path.
    always_comb begin
        control_state = 2'd3;
        alu_en        = 1'b0;
        reg_src       = 5'd0;
        case (r_state)
            ST_DECODE: control_state = 2'd0;
            ST_EXEC1: begin
                control_state = 2'd1;
                if (w_opcode == OPC_LDA) begin
                    alu_en  = 1'b1;
                    reg_src = 5'(A_REG_MAP);
                end else if (w_opcode == OPC_LDB) begin
                    alu_en  = 1'b1;
                    reg_src = 5'(B_REG_MAP);
                end else if (w_opcode == OPC_ALU) begin
                    alu_en  = 1'b1;
                end
            end
            ST_EXEC2: begin
                control_state = 2'd2;
                alu_en        = 1'b1;
            end
            default: control_state = 2'd3;
        endcase
    end

    assign instr_req   = (r_state == ST_FETCH);
    assign instr_addr  = r_pc;
    assign alu_op      = (w_opcode == OPC_ALU) ? OP_W'(r_ir[11:8]) : '0;
    assign operand_imm = ALU_WIDTH'(r_ir[7:0]);
    assign halted      = (r_state == ST_HALT);
    assign illegal_op  = (r_state == ST_DECODE) && w_illegal;

endmodule

// File: tb/tb_ucpu_control_unit.sv
// Scoreboard bench for ucpu_control_unit: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ucpu_control_unit;

    typedef struct packed {
        logic [1:0] cs;
        logic       req;
        logic [7:0] addr;
        logic       en;
        logic [3:0] op;
        logic [4:0] src;
        logic [7:0] imm;
        logic       hlt;
        logic       ill;
    } expT;

    logic        sysclk;
    logic        reset;
    logic        instrValid;
    logic [15:0] instrData;
    logic        ccGreater;
    logic        ccEqual;
    logic        instrReq;
    logic [7:0]  instrAddr;
    logic [1:0]  controlState;
    logic        aluEn;
    logic [3:0]  aluOp;
    logic [4:0]  regSrc;
    logic [7:0]  operandImm;
    logic        halted;
    logic        illegalOp;

    expT expQ[$];
    int  tagQ[$];
    int  stepNum = 0;
    int  compared = 0;
    int  mismatched = 0;

    ucpu_control_unit dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .instr_req    (instrReq),
        .instr_addr   (instrAddr),
        .instr_valid  (instrValid),
        .instr_data   (instrData),
        .cc_greater   (ccGreater),
        .cc_equal     (ccEqual),
        .control_state(controlState),
        .alu_en       (aluEn),
        .alu_op       (aluOp),
        .reg_src      (regSrc),
        .operand_imm  (operandImm),
        .halted       (halted),
        .illegal_op   (illegalOp)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    function automatic expT mk(input logic [1:0] cs, input logic req, input logic [7:0] addr,
                               input logic en, input logic [3:0] op, input logic [4:0] src,
                               input logic [7:0] imm, input logic hlt, input logic ill);
        expT e;
        e = '{cs: cs, req: req, addr: addr, en: en, op: op, src: src, imm: imm, hlt: hlt, ill: ill};
        return e;
    endfunction

    // Called just after a rising edge: drives this cycle's inputs and queues this cycle's outputs.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [15:0] data,
                                 input logic eq, input logic gt, input expT e);
        reset      = rst;
        instrValid = valid;
        instrData  = data;
        ccEqual    = eq;
        ccGreater  = gt;
        stepNum++;
        expQ.push_back(e);
        tagQ.push_back(stepNum);
        @(posedge sysclk);
        #1;
    endtask

    task automatic checkOutput(input expT e, input int tag);
        expT act;
        act = '{cs: controlState, req: instrReq, addr: instrAddr, en: aluEn, op: aluOp,
                src: regSrc, imm: operandImm, hlt: halted, ill: illegalOp};
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("[TB] FAIL step%0d: got cs=%0d req=%0b addr=%h en=%0b op=%h src=%0d imm=%h hlt=%0b ill=%0b, want cs=%0d req=%0b addr=%h en=%0b op=%h src=%0d imm=%h hlt=%0b ill=%0b",
                     tag, act.cs, act.req, act.addr, act.en, act.op, act.src, act.imm, act.hlt, act.ill,
                     e.cs, e.req, e.addr, e.en, e.op, e.src, e.imm, e.hlt, e.ill);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is one observed output.
    always @(negedge sysclk) begin
        if (expQ.size() > 0)
            checkOutput(expQ.pop_front(), tagQ.pop_front());
    end

    initial begin
        reset      = 1'b1;
        instrValid = 1'b0;
        instrData  = 16'h0000;
        ccEqual    = 1'b0;
        ccGreater  = 1'b0;
        @(posedge sysclk);
        #1;

        // Reset values
        applyStimulus(1, 0, 16'h0000, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(1, 1, 16'h1234, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));

        // NOP: 3,0,3 with address 0 -> 1
        applyStimulus(0, 1, 16'h0000, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h01, 0, 4'h0, 0, 8'h00, 0, 0));

        // LDA 0x05
        applyStimulus(0, 1, 16'h1005, 0, 0, mk(3, 1, 8'h01, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h02, 0, 4'h0, 0, 8'h05, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(1, 0, 8'h02, 1, 4'h0, 16, 8'h05, 0, 0));

        // ALU ADD: 3,0,1,2,3
        applyStimulus(0, 1, 16'h3100, 0, 0, mk(3, 1, 8'h02, 0, 4'h0, 0, 8'h05, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h03, 0, 4'h1, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(1, 0, 8'h03, 1, 4'h1, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(2, 0, 8'h03, 1, 4'h1, 0, 8'h00, 0, 0));

        // Fetch stall for 5 cycles, pc held
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 16'hFFFF, 0, 0, mk(3, 1, 8'h03, 0, 4'h1, 0, 8'h00, 0, 0));

        // JMP 0x10, with valid/data driven during DECODE and EXECUTE1 that must be ignored
        applyStimulus(0, 1, 16'h6010, 0, 0, mk(3, 1, 8'h03, 0, 4'h1, 0, 8'h00, 0, 0));
        applyStimulus(0, 1, 16'h1FFF, 0, 0, mk(0, 0, 8'h04, 0, 4'h0, 0, 8'h10, 0, 0));
        applyStimulus(0, 1, 16'h1FFF, 0, 0, mk(1, 0, 8'h04, 0, 4'h0, 0, 8'h10, 0, 0));

        // BEQ -4 taken from pc 0x11 -> 0x0D
        applyStimulus(0, 1, 16'h40FC, 0, 0, mk(3, 1, 8'h10, 0, 4'h0, 0, 8'h10, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h11, 0, 4'h0, 0, 8'hFC, 0, 0));
        applyStimulus(0, 0, 16'h0000, 1, 0, mk(1, 0, 8'h11, 0, 4'h0, 0, 8'hFC, 0, 0));

        // BEQ not taken (cc_greater set must not matter)
        applyStimulus(0, 1, 16'h40FC, 0, 0, mk(3, 1, 8'h0D, 0, 4'h0, 0, 8'hFC, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h0E, 0, 4'h0, 0, 8'hFC, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 1, mk(1, 0, 8'h0E, 0, 4'h0, 0, 8'hFC, 0, 0));

        // BGT +3 taken from pc 0x0F -> 0x12
        applyStimulus(0, 1, 16'h5003, 0, 0, mk(3, 1, 8'h0E, 0, 4'h0, 0, 8'hFC, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h0F, 0, 4'h0, 0, 8'h03, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 1, mk(1, 0, 8'h0F, 0, 4'h0, 0, 8'h03, 0, 0));

        // BGT -128 not taken (cc_equal set must not matter)
        applyStimulus(0, 1, 16'h5080, 0, 0, mk(3, 1, 8'h12, 0, 4'h0, 0, 8'h03, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h13, 0, 4'h0, 0, 8'h80, 0, 0));
        applyStimulus(0, 0, 16'h0000, 1, 0, mk(1, 0, 8'h13, 0, 4'h0, 0, 8'h80, 0, 0));

        // JMP 0x00, then BEQ -2 from pc 0x01 wraps to 0xFF
        applyStimulus(0, 1, 16'h6000, 0, 0, mk(3, 1, 8'h13, 0, 4'h0, 0, 8'h80, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h14, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(1, 0, 8'h14, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 1, 16'h40FE, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h01, 0, 4'h0, 0, 8'hFE, 0, 0));
        applyStimulus(0, 0, 16'h0000, 1, 0, mk(1, 0, 8'h01, 0, 4'h0, 0, 8'hFE, 0, 0));

        // LDB 0xAA at 0xFF, pc wraps to 0x00
        applyStimulus(0, 1, 16'h20AA, 0, 0, mk(3, 1, 8'hFF, 0, 4'h0, 0, 8'hFE, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h00, 0, 4'h0, 0, 8'hAA, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(1, 0, 8'h00, 1, 4'h0, 17, 8'hAA, 0, 0));

        // Illegal opcode pulses once, next fetch at pc+1
        applyStimulus(0, 1, 16'h7ABC, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'hAA, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h01, 0, 4'h0, 0, 8'hBC, 0, 1));

        // HALT is terminal
        applyStimulus(0, 1, 16'hF000, 0, 0, mk(3, 1, 8'h01, 0, 4'h0, 0, 8'hBC, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h02, 0, 4'h0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 16'h1055, 1, 1, mk(3, 0, 8'h02, 0, 4'h0, 0, 8'h00, 1, 0));

        // Reset out of HALT, then ALU op 0xA interrupted by reset in EXECUTE2
        applyStimulus(1, 0, 16'h0000, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 1, 16'h3A07, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h01, 0, 4'hA, 0, 8'h07, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(1, 0, 8'h01, 1, 4'hA, 0, 8'h07, 0, 0));
        applyStimulus(1, 0, 16'h0000, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 1, 16'h0000, 0, 0, mk(3, 1, 8'h00, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(0, 0, 8'h01, 0, 4'h0, 0, 8'h00, 0, 0));
        applyStimulus(0, 0, 16'h0000, 0, 0, mk(3, 1, 8'h01, 0, 4'h0, 0, 8'h00, 0, 0));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expQ.size() > 0; i++)
            @(posedge sysclk);
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ucpu_control_unit.md
# ucpu_control_unit

Instruction fetch/decode sequencer for the micro-CPU, sitting directly upstream of the ALU interface unit. It fetches 16-bit instructions over a request/valid handshake, holds the current instruction, and steps the shared `control_state` sequence DECODE → EXECUTE1 → EXECUTE2. It drives `alu_en`, `alu_op`, `reg_src` and `operand_imm` in the form the ALU interface consumes, and it uses the ALU's registered `cc_greater`/`cc_equal` flags for conditional branches.

## Interface
- `ALU_WIDTH`, 8, data and immediate width
- `ALU_OPS`, 16, number of ALU op codes; `alu_op` is $clog2(ALU_OPS) = 4 bits wide
- `PC_WIDTH`, 8, program counter and instruction address width
- `A_REG_MAP`, 16, `reg_src` code selecting ALU operand register A
- `B_REG_MAP`, 17, `reg_src` code selecting ALU operand register B
- `sysclk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `instr_req` out 1: fetch request
- `instr_addr` out PC_WIDTH: fetch address, equal to `pc`
- `instr_valid` in 1: `instr_data` is valid this cycle
- `instr_data` in 16: instruction word
- `cc_greater`, `cc_equal` in 1 each: registered ALU flags
- `control_state` out 2: 0=DECODE, 1=EXECUTE1, 2=EXECUTE2, 3=FETCH
- `alu_en` out 1: ALU interface enable
- `alu_op` out 4: ALU operation code
- `reg_src` out 5: destination register select
- `operand_imm` out ALU_WIDTH: immediate value for the A/B bus mux
- `halted` out 1: HALT executed
- `illegal_op` out 1: one-cycle pulse when an undefined opcode is decoded

## Operation
- Registers:
  - `pc` (PC_WIDTH bits)
  - `ir` (16 bits)
  - `state` ∈ {FETCH, DECODE, EXECUTE1, EXECUTE2, HALT}
- All outputs are functions of `state`, `ir` and `pc` only. No input-to-output combinational path exists.
- Opcode is `ir[15:12]`:
  - 0x0 NOP
  - 0x1 LDA: `operand_imm`=`ir[7:0]`
  - 0x2 LDB: `operand_imm`=`ir[7:0]`
  - 0x3 ALU: `alu_op`=`ir[11:8]`
  - 0x4 BEQ: signed offset `ir[7:0]`
  - 0x5 BGT: signed offset `ir[7:0]`
  - 0x6 JMP: absolute target `ir[PC_WIDTH-1:0]`
  - 0xF HALT
  - 0x7–0xE illegal
- FETCH: `instr_req`=1. When `instr_valid`=1: `ir`←`instr_data`, `pc`←`pc`+1 (wraps mod 2^PC_WIDTH), go to DECODE. Otherwise stay in FETCH with no timeout.
- DECODE (exactly 1 cycle):
  - NOP → FETCH.
  - Illegal opcode → `illegal_op`=1 this cycle, then FETCH (behaves as NOP).
  - HALT → HALT.
  - All other opcodes → EXECUTE1.
- EXECUTE1 (1 cycle):
  - LDA: `alu_en`=1, `reg_src`=A_REG_MAP → FETCH.
  - LDB: `alu_en`=1, `reg_src`=B_REG_MAP → FETCH.
  - ALU: `alu_en`=1, `reg_src`=0 → EXECUTE2.
  - BEQ/BGT/JMP: `alu_en`=0. On taken, `pc` is updated at the end of this cycle → FETCH.
- EXECUTE2 (ALU only, 1 cycle): `alu_en`=1, `alu_op` held → FETCH.
- Branches:
  - BEQ is taken if `cc_equal`=1. BGT is taken if `cc_greater`=1. Flags are sampled in EXECUTE1.
  - Taken: `pc` ← `pc` + sign-extend(`ir[7:0]`), truncated to PC_WIDTH. The `pc` used is already incremented past the branch.
  - Not taken: `pc` is unchanged.
  - JMP: `pc` ← `ir[PC_WIDTH-1:0]`.
- Output defaults:
  - `alu_en`=0, `reg_src`=0 outside the cases listed above.
  - `alu_op`=`ir[11:8]` when opcode is ALU, otherwise 0.
  - `operand_imm`=`ir[7:0]` in every state.
- HALT: terminal state. `control_state`=3, `instr_req`=0, `halted`=1. Only `reset` exits it.

## Timing
- Reset (asynchronous, takes effect immediately, mid-instruction included):
  - `state`=FETCH, `pc`=0, `ir`=0.
  - Resulting outputs: `control_state`=3, `instr_req`=1, `instr_addr`=0, `alu_en`=0, `alu_op`=0, `reg_src`=0, `operand_imm`=0, `halted`=0, `illegal_op`=0.
- Instruction cost with `instr_valid` in the first FETCH cycle:
  - NOP and illegal: 2 cycles.
  - LDA, LDB, BEQ, BGT, JMP: 3 cycles.
  - ALU: 4 cycles.
  - Each wait cycle adds 1.
- The ALU result and flags register at the end of EXECUTE2. A compare followed immediately by BEQ/BGT sees the new flags, because at least FETCH and DECODE intervene.
- `instr_valid` is ignored outside FETCH.
- `instr_data` is sampled only in the cycle where `instr_req` and `instr_valid` are both 1.
- Branch to a wrapped address is legal. For example, with PC_WIDTH=8, `pc`=0x01 plus offset 0xFE gives 0xFF.

## Test plan
- Reset then fetch: assert `reset`; check all reset values. Release `reset`; present `instr_data`=0x0000 with `instr_valid` high for 1 cycle → `control_state` sequence 3,0,3, `instr_addr` 0→1.
- Load then ALU op: LDA 0x1005 then ALU ADD 0x3100, zero-wait. Required response:
  - LDA EXECUTE1: `alu_en`=1, `reg_src`=16, `operand_imm`=0x05.
  - ADD: `alu_op`=1 with `alu_en`=1 in both EXECUTE1 and EXECUTE2; `control_state` 3,0,1,2,3.
- Branches: with `cc_equal`=1 and `pc` after fetch = 0x11, BEQ offset 0xFC → `instr_addr`=0x0D. With `cc_equal`=0 → `instr_addr`=0x11. BGT behaves the same way with `cc_greater`.
- Fetch stall: hold `instr_valid`=0 for 5 cycles → `control_state` stays 3 and `pc` is unchanged. With `instr_valid` asserted while in DECODE, `ir` does not change.
- Illegal opcode and HALT:
  - 0x7ABC → `illegal_op` pulses exactly 1 cycle in DECODE; the next fetch is at `pc`+1.
  - 0xF000 → `halted`=1 and `instr_req`=0 indefinitely, until `reset`.
- Reset mid-instruction: assert `reset` during EXECUTE2 of an ALU op → `alu_en` drops to 0 immediately and the next fetch is from address 0.
